// File: rtl/hazard_unit.sv
// Hazard unit: tracks EX/MEM/WB shadow slots to generate registered forwarding
// selects, one-cycle load-use stalls and branch/jump wrong-path flushes.
module hazard_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_Valid,
    input  logic [2:0] ID_Rs,
    input  logic [2:0] ID_Rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic [2:0] ID_Rd,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       BranchJumpTaken,
    output logic [1:0] ForwardALUOp1,
    output logic [1:0] ForwardALUOp2,
    output logic       StallFD,
    output logic       BubbleDE,
    output logic       FlushFD,
    output logic       Err
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_EX  = 2'b10;

    state_t state, state_next;

    logic       ex_valid, ex_regwrite, ex_memread;
    logic [2:0] ex_rd;
    logic       mem_valid, mem_regwrite, mem_memread;
    logic [2:0] mem_rd;
    logic       wb_valid, wb_regwrite, wb_memread;
    logic [2:0] wb_rd;

    logic       load_use;
    logic       ex_load;
    logic [1:0] fwd1_next, fwd2_next;

    // A load in EX whose result a live source operand of the decode instruction needs.
    always_comb begin
        load_use = 1'b0;
        if (ex_valid && ex_memread && ex_regwrite && ID_Valid) begin
            if ((ID_UsesRs && (ex_rd == ID_Rs)) || (ID_UsesRt && (ex_rd == ID_Rt)))
                load_use = 1'b1;
        end
    end

    // A taken branch/jump wins over a stall because the decode instruction is wrong-path.
    always_comb begin
        state_next = RUN;
        StallFD    = 1'b0;
        BubbleDE   = 1'b0;
        FlushFD    = 1'b0;
        unique case (state)
            RUN: begin
                if (BranchJumpTaken) begin
                    FlushFD  = 1'b1;
                    BubbleDE = 1'b1;
                end else if (load_use) begin
                    StallFD    = 1'b1;
                    BubbleDE   = 1'b1;
                    state_next = STALL;
                end
            end
            STALL: begin
                if (BranchJumpTaken) begin
                    FlushFD  = 1'b1;
                    BubbleDE = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign ex_load = ID_Valid & ~BubbleDE;

    always_comb begin
        fwd1_next = FWD_RF;
        fwd2_next = FWD_RF;
        if (ID_UsesRs) begin
            if (ex_valid && ex_regwrite && (ex_rd == ID_Rs))
                fwd1_next = FWD_EX;
            else if (mem_valid && mem_regwrite && (mem_rd == ID_Rs))
                fwd1_next = FWD_MEM;
        end
        if (ID_UsesRt) begin
            if (ex_valid && ex_regwrite && (ex_rd == ID_Rt))
                fwd2_next = FWD_EX;
            else if (mem_valid && mem_regwrite && (mem_rd == ID_Rt))
                fwd2_next = FWD_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    // The shadow advances every cycle; EX takes a bubble whenever decode does not issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rd        <= 3'd0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= 3'd0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= 3'd0;
            wb_regwrite  <= 1'b0;
            wb_memread   <= 1'b0;
        end else begin
            wb_valid     <= mem_valid;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            wb_memread   <= mem_memread;
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            ex_valid     <= ex_load;
            ex_rd        <= ID_Rd;
            ex_regwrite  <= ID_RegWrite;
            ex_memread   <= ID_MemRead;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ForwardALUOp1 <= FWD_RF;
            ForwardALUOp2 <= FWD_RF;
        end else if (ex_load) begin
            ForwardALUOp1 <= fwd1_next;
            ForwardALUOp2 <= fwd2_next;
        end else begin
            ForwardALUOp1 <= FWD_RF;
            ForwardALUOp2 <= FWD_RF;
        end
    end

    // A redirect with nothing in EX means the surrounding pipeline broke protocol.
    always_ff @(posedge clk) begin
        if (rst)
            Err <= 1'b0;
        else if (BranchJumpTaken && !ex_valid)
            Err <= 1'b1;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block that produces the execute stage's operand-forwarding selects (`ForwardALUOp1`/`ForwardALUOp2`) and consumes its `BranchJumpTaken` flag. It sits beside the decode stage and keeps its own three-slot shadow of in-flight instructions (EX, MEM, WB). From that shadow it:
- computes forwarding selects,
- detects load-use hazards and stalls for one cycle,
- squashes wrong-path instructions when execute redirects the PC.

## Interface
Parameters:
- none; register specifiers are fixed at 3 bits (8 GPRs, r0 is an ordinary register).

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ID_Valid`  in  1  decode stage holds a real instruction
- `ID_Rs`  in  3  first source register of the decode instruction
- `ID_Rt`  in  3  second source register of the decode instruction
- `ID_UsesRs`  in  1  decode instruction reads Rs through ALUOp1
- `ID_UsesRt`  in  1  decode instruction reads Rt through ALUOp2 (0 when the immediate is used)
- `ID_Rd`  in  3  destination register of the decode instruction
- `ID_RegWrite`  in  1  decode instruction writes `ID_Rd`
- `ID_MemRead`  in  1  decode instruction is a load
- `BranchJumpTaken`  in  1  execute stage redirects the PC this cycle
- `ForwardALUOp1`  out  2  registered; 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result
- `ForwardALUOp2`  out  2  registered; same encoding
- `StallFD`  out  1  combinational; hold the PC and the IF/ID register
- `BubbleDE`  out  1  combinational; load a NOP into the ID/EX register
- `FlushFD`  out  1  combinational; load a NOP into the IF/ID register
- `Err`  out  1  registered, sticky protocol error

## Operation
- **Shadow slots.** Each of EX, MEM and WB holds `{valid, rd, regwrite, memread}`.
  - Every cycle: MEM→WB, EX→MEM.
  - EX receives the ID fields when `ID_Valid & ~BubbleDE`; otherwise EX receives a bubble (valid = 0).
- **Producer test.** A slot *produces* register r when valid & regwrite & rd == r.
- **Forwarding selects.** Computed for the decode instruction and registered so that they align with it in EX.
  - Op1 when `ID_UsesRs`: EX slot produces `ID_Rs` → 10; else MEM slot produces it → 01; else 00.
  - Op2 uses the same rule with `ID_UsesRt`/`ID_Rt`.
  - 10 has priority over 01, so the youngest producer wins.
  - A select of 11 is never generated.
  - When EX receives a bubble, both selects register as 00.
- **Register file.** It is write-through, so a WB-slot producer needs no forwarding.
- **Load-use hazard.** Raised when the EX slot is valid & memread & regwrite, and rd equals a used source of a valid ID instruction.
- **State machine.**
  - RUN: on a load-use hazard with `BranchJumpTaken` = 0, assert `StallFD` = 1 and `BubbleDE` = 1, then go to STALL.
  - STALL: lasts exactly one cycle and returns to RUN. The load is now in MEM, so the dependent instruction gets select 01 when it enters EX.
  - A second hazard is impossible in STALL because the EX slot is a bubble. `StallFD` = 0 in STALL.
- **Flush.** When `BranchJumpTaken` = 1:
  - assert `FlushFD` = 1 and `BubbleDE` = 1;
  - force `StallFD` = 0 (a flush overrides a simultaneous load-use stall, because the ID instruction is wrong-path);
  - next state is RUN.
- **Err.** Set when `BranchJumpTaken` = 1 while the EX slot is invalid. It stays set until `rst`.

## Timing
- **Reset** (synchronous, takes effect at the edge where `rst` = 1):
  - all slot valids = 0, state = RUN;
  - `ForwardALUOp1` = `ForwardALUOp2` = 00, `Err` = 0;
  - combinational outputs evaluate to 0 because the slots are empty.
  - `rst` asserted mid-stall or mid-flush discards all in-flight tracking; the next cycle behaves as an empty pipeline.
- **Forwarding latency.** 1 cycle: a select computed in cycle n while the instruction is in ID is presented in cycle n+1 while it is in EX.
- **Stall, flush and bubble latency.** 0 cycles: outputs are combinational from the slot state plus the ID and `BranchJumpTaken` inputs.
- **Load-use sequence.**
  - Cycle n: load in EX, consumer in ID; `StallFD` = `BubbleDE` = 1.
  - Cycle n+1: bubble in EX, load in MEM, consumer still in ID; no stall.
  - Cycle n+2: consumer in EX with select 01.
- **No combinational path** from `BranchJumpTaken` to the `Forward*` outputs except through the bubble registration.

## Test plan
- **EX forward.** `add r3` enters (RegWrite = 1, Rd = 3), then next cycle a consumer with Rs = 3, UsesRs = 1 → one cycle later `ForwardALUOp1` = 10, `ForwardALUOp2` = 00, no stall.
- **MEM forward and priority.**
  - Producer Rd = 5, one independent instruction, then a consumer with Rt = 5 → `ForwardALUOp2` = 01.
  - Two back-to-back producers of r5 → consumer gets 10.
- **Load-use.** `ld r2` followed immediately by a consumer with Rs = 2 → `StallFD` = `BubbleDE` = 1 for exactly one cycle; the consumer reaches EX two cycles later with `ForwardALUOp1` = 01.
- **Flush overrides stall.** A load-use hazard and `BranchJumpTaken` = 1 in the same cycle → `FlushFD` = 1, `BubbleDE` = 1, `StallFD` = 0; next-cycle selects = 00; state RUN.
- **Unused operand.** Immediate-form consumer (UsesRt = 0) with Rt matching an EX producer → `ForwardALUOp2` = 00.
  - A load whose Rd matches only an unused Rt → no stall.
- **Reset mid-stall and Err.**
  - `rst` during STALL → all outputs 0 next cycle.
  - `BranchJumpTaken` = 1 on an empty pipeline → `Err` = 1 and it holds until `rst`.
